alu_issue_stage: RTL and testbench

Decode-and-issue stage that produces the ALU's full input bundle: 4-bit operation code, shift amount, operand A and the muxed operand B. Decodes a 32-bit MIPS instruction plus its two register-file read values, then presents the registered result to the ALU through a valid/ready handshake. A 2-entry skid buffer lets the stage hold a full bundle under back-pressure without stalling combinationally on the upstream side.

---
 rtl/alu_pkg.sv | 67 ++++++
 rtl/skid_buffer.sv | 74 +++++++
 rtl/alu_issue_stage.sv | 133 +++++++++++++
 tb/tb_alu_issue_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU codes, MIPS opcode/funct constants and the issue bundle type.
package alu_pkg;

    localparam logic [3:0] AluAnd     = 4'b0000;
    localparam logic [3:0] AluOr      = 4'b0001;
    localparam logic [3:0] AluAdd     = 4'b0010;
    localparam logic [3:0] AluXor     = 4'b0011;
    localparam logic [3:0] AluSll     = 4'b0100;
    localparam logic [3:0] AluSgt     = 4'b0101;
    localparam logic [3:0] AluSub     = 4'b0110;
    localparam logic [3:0] AluSlt     = 4'b0111;
    localparam logic [3:0] AluSrl     = 4'b1000;
    localparam logic [3:0] AluSra     = 4'b1001;
    localparam logic [3:0] AluLui     = 4'b1010;
    localparam logic [3:0] AluNor     = 4'b1100;
    localparam logic [3:0] AluIllegal = 4'b1111;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSra  = 6'h03;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic [4:0]  inst_10_6;
        logic [31:0] read_data_1;
        logic [31:0] alu_mux_output;
        logic        illegal;
    } alu_bundle_t;

    localparam int unsigned AluBundleWidth = $bits(alu_bundle_t);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } skid_state_e;

    typedef enum logic [1:0] {
        BZero,
        BRt,
        BSext,
        BZext
    } opb_sel_e;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: main register drives the outputs, skid register absorbs one extra
// bundle so in_ready never depends on out_ready.
module skid_buffer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 74
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;
    logic             drain;

    assign in_ready  = (state_q != StFull) & ~rst;
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && drain) begin
                    main_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = StFull;
                end else if (drain) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // in_ready is low here, so only a drain can happen
                if (drain) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode a MIPS instruction into the ALU input bundle and issue it through a skid buffer.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter logic [5:0] SGT_FUNCT = 6'h2C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_ctrl,
    output logic [4:0]  inst_10_6,
    output logic [31:0] read_data_1,
    output logic [31:0] alu_mux_output,
    output logic        illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [3:0]  ctrl;
    opb_sel_e    b_sel;
    alu_bundle_t dec_bundle;
    alu_bundle_t out_bundle;
    logic        unused_reg_fields;

    assign opcode            = instr[31:26];
    assign funct             = instr[5:0];
    assign imm               = instr[15:0];
    // Register numbers arrive already resolved as rs_data/rt_data
    assign unused_reg_fields = ^instr[25:16];

    always_comb begin
        ctrl  = AluIllegal;
        b_sel = BZero;
        case (opcode)
            OpRtype: begin
                b_sel = BRt;
                if (funct == SGT_FUNCT) begin
                    ctrl = AluSgt;
                end else begin
                    case (funct)
                        FnAdd, FnAddu: ctrl = AluAdd;
                        FnSub, FnSubu: ctrl = AluSub;
                        FnAnd:         ctrl = AluAnd;
                        FnOr:          ctrl = AluOr;
                        FnXor:         ctrl = AluXor;
                        FnNor:         ctrl = AluNor;
                        FnSlt:         ctrl = AluSlt;
                        FnSll:         ctrl = AluSll;
                        FnSrl:         ctrl = AluSrl;
                        FnSra:         ctrl = AluSra;
                        default: begin
                            ctrl  = AluIllegal;
                            b_sel = BZero;
                        end
                    endcase
                end
            end
            OpAddi, OpAddiu, OpLw, OpSw: begin
                ctrl  = AluAdd;
                b_sel = BSext;
            end
            OpSlti: begin
                ctrl  = AluSlt;
                b_sel = BSext;
            end
            OpAndi: begin
                ctrl  = AluAnd;
                b_sel = BZext;
            end
            OpOri: begin
                ctrl  = AluOr;
                b_sel = BZext;
            end
            OpXori: begin
                ctrl  = AluXor;
                b_sel = BZext;
            end
            // The ALU itself shifts the immediate into the upper half
            OpLui: begin
                ctrl  = AluLui;
                b_sel = BZext;
            end
            OpBeq, OpBne: begin
                ctrl  = AluSub;
                b_sel = BRt;
            end
            default: begin
                ctrl  = AluIllegal;
                b_sel = BZero;
            end
        endcase
    end

    always_comb begin
        dec_bundle.alu_ctrl    = ctrl;
        dec_bundle.inst_10_6   = instr[10:6];
        dec_bundle.read_data_1 = rs_data;
        dec_bundle.illegal     = (ctrl == AluIllegal);
        case (b_sel)
            BRt:     dec_bundle.alu_mux_output = rt_data;
            BSext:   dec_bundle.alu_mux_output = {{16{imm[15]}}, imm};
            BZext:   dec_bundle.alu_mux_output = {16'h0000, imm};
            default: dec_bundle.alu_mux_output = '0;
        endcase
    end

    skid_buffer #(
        .WIDTH(AluBundleWidth)
    ) u_skid_buffer (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (dec_bundle),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_bundle)
    );

    assign alu_ctrl       = out_bundle.alu_ctrl;
    assign inst_10_6      = out_bundle.inst_10_6;
    assign read_data_1    = out_bundle.read_data_1;
    assign alu_mux_output = out_bundle.alu_mux_output;
    assign illegal        = out_bundle.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: FIFO reference model checked every cycle plus directed literals.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic [4:0]  inst_10_6;
    logic [31:0] read_data_1;
    logic [31:0] alu_mux_output;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } exp_t;

    exp_t model_q[$];
    bit   started = 0;

    alu_issue_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_ctrl      (alu_ctrl),
        .inst_10_6     (inst_10_6),
        .read_data_1   (read_data_1),
        .alu_mux_output(alu_mux_output),
        .illegal       (illegal)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode, straight from the opcode/funct tables (numbers in decimal)
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs,
                                   input logic [31:0] rt);
        exp_t e;
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        e.a    = rs;
        e.sh   = ins[10:6];
        e.ctrl = 4'd15;
        e.b    = 0;
        e.ill  = 1;
        if (op == 0) begin
            e.ill = 0;
            e.b   = rt;
            if (fn == 44)                 e.ctrl = 5;
            else if (fn == 32 || fn == 33) e.ctrl = 2;
            else if (fn == 34 || fn == 35) e.ctrl = 6;
            else if (fn == 36)            e.ctrl = 0;
            else if (fn == 37)            e.ctrl = 1;
            else if (fn == 38)            e.ctrl = 3;
            else if (fn == 39)            e.ctrl = 12;
            else if (fn == 42)            e.ctrl = 7;
            else if (fn == 0)             e.ctrl = 4;
            else if (fn == 2)             e.ctrl = 8;
            else if (fn == 3)             e.ctrl = 9;
            else begin
                e.ill = 1;
                e.b   = 0;
            end
        end else if (op == 8 || op == 9 || op == 35 || op == 43 || op == 10) begin
            e.ill  = 0;
            e.ctrl = (op == 10) ? 4'd7 : 4'd2;
            e.b    = 32'($signed(ins[15:0]));
        end else if (op >= 12 && op <= 15) begin
            e.ill = 0;
            e.b   = 32'(ins[15:0]);
            case (op)
                12:      e.ctrl = 0;
                13:      e.ctrl = 1;
                14:      e.ctrl = 3;
                default: e.ctrl = 10;
            endcase
        end else if (op == 4 || op == 5) begin
            e.ill  = 0;
            e.ctrl = 6;
            e.b    = rt;
        end
        return e;
    endfunction

    // FIFO model of the stage: up to two bundles in flight
    always @(posedge clk) begin
        bit acc;
        bit drn;
        started = 1;
        if (rst) begin
            model_q.delete();
        end else begin
            acc = in_valid && (model_q.size() < 2);
            drn = out_ready && (model_q.size() > 0);
            if (drn) void'(model_q.pop_front());
            if (acc) model_q.push_back(model(instr, rs_data, rt_data));
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cmp_in_ready", 32'(in_ready), 32'(!rst && model_q.size() < 2));
            chk("cmp_out_valid", 32'(out_valid), 32'(model_q.size() > 0));
            if (model_q.size() > 0) begin
                chk("cmp_alu_ctrl", 32'(alu_ctrl), 32'(model_q[0].ctrl));
                chk("cmp_inst_10_6", 32'(inst_10_6), 32'(model_q[0].sh));
                chk("cmp_read_data_1", read_data_1, model_q[0].a);
                chk("cmp_alu_mux_output", alu_mux_output, model_q[0].b);
                chk("cmp_illegal", 32'(illegal), 32'(model_q[0].ill));
            end
        end
    end

    task automatic issue(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
        @(posedge clk);
        #1;
        in_valid = 1;
        instr    = i;
        rs_data  = r1;
        rt_data  = r2;
        @(posedge clk);
        #1;
        in_valid = 0;
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [3:0] c, input logic [4:0] s,
                              input logic [31:0] a, input logic [31:0] b, input logic il);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_ctrl"}, 32'(alu_ctrl), 32'(c));
        chk({name, "_shamt"}, 32'(inst_10_6), 32'(s));
        chk({name, "_opa"}, read_data_1, a);
        chk({name, "_opb"}, alu_mux_output, b);
        chk({name, "_illegal"}, 32'(illegal), 32'(il));
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] r1);
        in_valid = 1;
        instr    = i;
        rs_data  = r1;
        rt_data  = r1 + 1;
    endtask

    initial begin
        rst       = 1;
        in_valid  = 0;
        out_ready = 1;
        instr     = 0;
        rs_data   = 0;
        rt_data   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_in_ready_after", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_shamt", 32'(inst_10_6), 32'd0);
        chk("rst_opa", read_data_1, 32'd0);
        chk("rst_opb", alu_mux_output, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);

        // Single-issue decode vectors with out_ready held high
        issue(32'h00221821, 32'd5, 32'd7);
        expect_out("addu", 4'b0010, 5'd0, 32'd5, 32'd7, 1'b0);
        issue(32'h2000FFFC, 32'h10, 32'h99);
        expect_out("addi", 4'b0010, 5'd31, 32'h10, 32'hFFFFFFFC, 1'b0);
        issue(32'h34008001, 32'h1, 32'h2);
        expect_out("ori", 4'b0001, 5'd0, 32'h1, 32'h00008001, 1'b0);
        issue(32'h3C001234, 32'h3, 32'h4);
        expect_out("lui", 4'b1010, 5'd8, 32'h3, 32'h00001234, 1'b0);
        issue(32'h00000103, 32'h6, 32'h80000000);
        expect_out("sra", 4'b1001, 5'd4, 32'h6, 32'h80000000, 1'b0);
        issue(32'h0000002C, 32'd3, 32'd9);
        expect_out("sgt", 4'b0101, 5'd0, 32'd3, 32'd9, 1'b0);
        issue(32'h10000000, 32'h44, 32'h55);
        expect_out("beq", 4'b0110, 5'd0, 32'h44, 32'h55, 1'b0);
        issue(32'h28008000, 32'h7, 32'h8);
        expect_out("slti", 4'b0111, 5'd0, 32'h7, 32'hFFFF8000, 1'b0);
        issue(32'h3800F0F0, 32'h9, 32'hA);
        expect_out("xori", 4'b0011, 5'd3, 32'h9, 32'h0000F0F0, 1'b0);
        issue(32'hFC000000, 32'hAB, 32'hCD);
        expect_out("ill_op", 4'b1111, 5'd0, 32'hAB, 32'h0, 1'b1);
        @(negedge clk);
        chk("ill_drained", 32'(out_valid), 32'd0);
        issue(32'h00000001, 32'hEE, 32'hFF);
        expect_out("ill_fn", 4'b1111, 5'd0, 32'hEE, 32'h0, 1'b1);

        // Back-pressure: A and B fill the buffer, C waits
        @(posedge clk);
        #1 out_ready = 0;
        drive(32'h00221821, 32'h11);
        @(posedge clk);
        #1 drive(32'h00221821, 32'h22);
        @(posedge clk);
        #1 drive(32'h00221821, 32'h33);
        @(negedge clk);
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        chk("bp_head_a", read_data_1, 32'h11);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_hold_a", read_data_1, 32'h11);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 out_ready = 1;
        @(negedge clk);
        chk("bp_ready_indep", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_head_b", read_data_1, 32'h22);
        chk("bp_ready_again", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        chk("bp_head_c", read_data_1, 32'h33);
        @(negedge clk);
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Reset while FULL discards both entries
        @(posedge clk);
        #1 out_ready = 0;
        drive(32'h00221821, 32'h44);
        @(posedge clk);
        #1 drive(32'h00221821, 32'h55);
        @(posedge clk);
        #1;
        rst = 1;
        drive(32'h00221821, 32'h66);
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_still_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst       = 0;
        in_valid  = 0;
        out_ready = 1;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_ctrl", 32'(alu_ctrl), 32'd0);
        chk("post_rst_shamt", 32'(inst_10_6), 32'd0);
        chk("post_rst_opa", read_data_1, 32'd0);
        chk("post_rst_opb", alu_mux_output, 32'd0);
        chk("post_rst_illegal", 32'(illegal), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("post_rst_no_stale", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
